// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the memory-bus arbiter slice.
// Optional stall timeout is enabled by defining ARB_TIMEOUT_EN.
package mem_bus_pkg;

    localparam int DATA_W                 = 8;
    localparam int ID_W                   = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_t;

    // A single requester still needs a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and downstream bus signals shared by the arbiter and its users.
// The arbiter uses the slave modport; requesters/downstream use master.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import mem_bus_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [ID_W*NUM_REQ-1:0]   req_id;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         bus_data;
    logic                      bus_valid;
    logic                      bus_ready;
    logic [ID_W-1:0]           bus_id;
    logic                      bus_busy;

    modport master (
        output req, req_id, req_data, req_valid, bus_ready,
        input  req_ready, grant, bus_data, bus_valid, bus_id, bus_busy
    );

    modport slave (
        input  req, req_id, req_data, req_valid, bus_ready,
        output req_ready, grant, bus_data, bus_valid, bus_id, bus_busy
    );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Rotating-priority picker: first unmasked request at or above ptr, wrapping.
// Purely combinational; produces a one-hot (or zero) winner.
module rr_pick
    import mem_bus_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     winner
);

    logic [N-1:0] eligible;
    logic [N-1:0] rotated;
    logic [N-1:0] pick;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    assign eligible = req & ~mask;
    assign rotated  = N'({eligible, eligible} >> ptr);
    assign pick     = rotated & (-rotated);
    assign winner   = N'(({pick, pick} << ptr) >> N);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbiter for a shared memory-interface bus (IDLE/GRANT/TURN).
// Define ARB_TIMEOUT_EN to add the stall counter, requester mask and timeout_evt.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_REQ        = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
`ifdef ARB_TIMEOUT_EN
    ,
    output logic             timeout_evt
`endif
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant_q, grant_nxt;
    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] mask;
    logic [PTR_W-1:0]   ptr, ptr_nxt;
    logic [PTR_W-1:0]   owner_idx, owner_inc;
    logic               owner_req;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0]   stall_cnt, stall_nxt;
    logic [NUM_REQ-1:0] mask_q, mask_nxt;
    logic               timeout_nxt;
    logic               handshake;

    assign mask      = mask_q;
    assign handshake = bus.bus_valid & bus.bus_ready;
`else
    assign mask = '0;
`endif

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (bus.req),
        .mask   (mask),
        .ptr    (ptr),
        .winner (winner)
    );

    // bus_valid is qualified by req so a beat offered in the release cycle never transfers.
    always_comb begin
        owner_idx     = '0;
        owner_req     = 1'b0;
        bus.bus_data  = '0;
        bus.bus_valid = 1'b0;
        bus.bus_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx     = PTR_W'(i);
                owner_req     = bus.req[i];
                bus.bus_data  = bus.req_data[i*DATA_W +: DATA_W];
                bus.bus_valid = bus.req_valid[i] & bus.req[i];
                bus.bus_id    = bus.req_id[i*ID_W +: ID_W];
            end
        end
    end

    assign owner_inc     = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + PTR_W'(1);
    assign bus.req_ready = grant_q & {NUM_REQ{bus.bus_ready}};
    assign bus.grant     = grant_q;
    assign bus.bus_busy  = |grant_q;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_q;
        ptr_nxt     = ptr;
`ifdef ARB_TIMEOUT_EN
        stall_nxt   = stall_cnt;
        mask_nxt    = mask_q & bus.req;
        timeout_nxt = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (|winner) begin
                    grant_nxt = winner;
                    state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
                    stall_nxt = '0;
`endif
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    grant_nxt = '0;
                    state_nxt = TURN;
                    ptr_nxt   = owner_inc;
                end
`ifdef ARB_TIMEOUT_EN
                else if (handshake) begin
                    stall_nxt = '0;
                end else if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Forced release; the owner stays masked until it lets go of req.
                    grant_nxt   = '0;
                    state_nxt   = TURN;
                    ptr_nxt     = owner_inc;
                    timeout_nxt = 1'b1;
                    mask_nxt    = mask_nxt | grant_q;
                end else begin
                    stall_nxt = stall_cnt + CNT_W'(1);
                end
`endif
            end
            TURN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= '0;
            ptr         <= '0;
`ifdef ARB_TIMEOUT_EN
            stall_cnt   <= '0;
            mask_q      <= '0;
            timeout_evt <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            grant_q     <= grant_nxt;
            ptr         <= ptr_nxt;
`ifdef ARB_TIMEOUT_EN
            stall_cnt   <= stall_nxt;
            mask_q      <= mask_nxt;
            timeout_evt <= timeout_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus queues expected grants/beats, a monitor checks them.
// The forced-release scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic [1:0] id;
    } beat_t;

    logic clk;
    logic rst;
`ifdef ARB_TIMEOUT_EN
    logic timeout_evt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    beat_t      exp_beat_q[$];
    logic [3:0] exp_grant_q[$];

    logic [7:0] data_tbl [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [1:0] id_tbl   [4] = '{2'd2, 2'd1, 2'd3, 2'd0};

    mem_bus_arbiter_if #(.NUM_REQ(4)) bus_if ();

    mem_bus_arbiter #(
        .NUM_REQ        (4)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (255)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if.slave)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_evt (timeout_evt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] v, input logic rdy);
        bus_if.req       = r;
        bus_if.req_valid = v;
        bus_if.bus_ready = rdy;
    endtask

    task automatic wait_grant(input logic [3:0] m, output int lat);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_if.grant === m) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) checkOutput("grant_wait", 32'(bus_if.grant), 32'(m));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Requester i takes the bus, moves n beats with bus_ready high, then lets go.
    task automatic serve(input int i, input int n, input logic [3:0] other,
                         input bit rearm, input int exp_lat);
        logic [3:0] oh;
        beat_t      b;
        int         lat;
        oh = 4'b0001 << i;
        exp_grant_q.push_back(oh);
        for (int k = 0; k < n; k++) begin
            b.g  = oh;
            b.d  = data_tbl[i];
            b.id = id_tbl[i];
            exp_beat_q.push_back(b);
        end
        bus_if.bus_ready    = 1'b1;
        bus_if.req[i]       = 1'b1;
        bus_if.req_valid[i] = 1'b1;
        wait_grant(oh, lat);
        if (exp_lat >= 0) checkOutput("grant_latency", 32'(lat), 32'(exp_lat));
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                bus_if.req       = bus_if.req | other;
                bus_if.req_valid = bus_if.req_valid | other;
            end
        end
        bus_if.req[i]       = 1'b0;
        bus_if.req_valid[i] = 1'b0;
        if (rearm) begin
            @(posedge clk);
            #1;
            bus_if.req[i]       = 1'b1;
            bus_if.req_valid[i] = 1'b1;
        end
    endtask

    // Monitor: pops expected grants on ownership changes and expected beats on handshakes.
    initial begin
        logic [3:0] prev_grant;
        int         idle_cnt;
        bit         owner_seen;
        beat_t      e;
        prev_grant = '0;
        idle_cnt   = 0;
        owner_seen = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_grant = '0;
                idle_cnt   = 0;
                owner_seen = 0;
                continue;
            end
            checkOutput("grant_onehot0", 32'($onehot0(bus_if.grant)), 32'd1);
            if (bus_if.grant !== prev_grant && bus_if.grant !== 4'b0000) begin
                if (exp_grant_q.size() == 0) checkOutput("grant_unexpected", 32'(bus_if.grant), 32'd0);
                else checkOutput("grant_order", 32'(bus_if.grant), 32'(exp_grant_q.pop_front()));
                if (owner_seen) checkOutput("turn_gap_ge2", 32'(idle_cnt >= 2), 32'd1);
                owner_seen = 1;
            end
            if (bus_if.grant === 4'b0000) begin
                idle_cnt++;
                checkOutput("idle_bus", {16'd0, bus_if.bus_busy, bus_if.bus_valid, bus_if.bus_data,
                                         bus_if.bus_id, bus_if.req_ready}, 32'd0);
            end else begin
                idle_cnt = 0;
                checkOutput("owner_ready", {27'd0, bus_if.bus_busy, bus_if.req_ready},
                            {27'd0, 1'b1, bus_if.grant & {4{bus_if.bus_ready}}});
            end
            if (bus_if.bus_valid && bus_if.bus_ready) begin
                if (exp_beat_q.size() == 0) begin
                    checkOutput("beat_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_beat_q.pop_front();
                    checkOutput("beat", {14'd0, bus_if.grant, bus_if.bus_data, bus_if.bus_id, bus_if.req_ready},
                                {14'd0, e.g, e.d, e.id, e.g});
                end
            end
            prev_grant = bus_if.grant;
        end
    end

    initial begin
        int lat;
        rst             = 1'b1;
        bus_if.req_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        bus_if.req_id   = {2'd0, 2'd3, 2'd1, 2'd2};
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        // Reset values
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_grant", 32'(bus_if.grant), 32'd0);
        checkOutput("rst_busy", 32'(bus_if.bus_busy), 32'd0);
        checkOutput("rst_valid", 32'(bus_if.bus_valid), 32'd0);
        checkOutput("rst_data", 32'(bus_if.bus_data), 32'd0);
        checkOutput("rst_id", 32'(bus_if.bus_id), 32'd0);
        checkOutput("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
`ifdef ARB_TIMEOUT_EN
        checkOutput("rst_timeout_evt", 32'(timeout_evt), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lone requester 0: payload 0xAA, id 2, one-cycle grant latency
        serve(0, 3, 4'b0000, 1'b0, 1);
        settle();

        // All four requesting from reset, each owner drops after 3 beats
        @(posedge clk);
        #1;
        rst = 1'b1;
        applyStimulus(4'b1111, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        serve(0, 3, 4'b0000, 1'b1, 1);
        serve(1, 3, 4'b0000, 1'b1, -1);
        serve(2, 3, 4'b0000, 1'b1, -1);
        serve(3, 3, 4'b0000, 1'b1, -1);
        serve(0, 3, 4'b0000, 1'b0, -1);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        settle();

        // Owner 0 holds while requester 1 rises: no preemption
        serve(0, 4, 4'b0010, 1'b0, 1);
        serve(1, 2, 4'b0000, 1'b0, -1);
        settle();

        // Reset during GRANT with bus_valid high; ptr returns to 0
        bus_if.bus_ready = 1'b0;
        exp_grant_q.push_back(4'b0100);
        bus_if.req[2]       = 1'b1;
        bus_if.req_valid[2] = 1'b1;
        wait_grant(4'b0100, lat);
        @(posedge clk);
        #1;
        bus_if.req[1]       = 1'b1;
        bus_if.req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_grant", 32'(bus_if.grant), 32'd0);
        checkOutput("post_rst_valid", 32'(bus_if.bus_valid), 32'd0);
        @(posedge clk);
        #1;
        serve(1, 2, 4'b0000, 1'b0, -1);
        bus_if.req[2]       = 1'b0;
        bus_if.req_valid[2] = 1'b0;
        settle();

        // Owner drops req with valid high and bus_ready low: no beat, bus idle in TURN
        bus_if.bus_ready = 1'b0;
        exp_grant_q.push_back(4'b1000);
        bus_if.req[3]       = 1'b1;
        bus_if.req_valid[3] = 1'b1;
        wait_grant(4'b1000, lat);
        @(posedge clk);
        #1;
        bus_if.req[3] = 1'b0;
        @(posedge clk);
        #1;
        bus_if.bus_ready = 1'b1;
        @(negedge clk);
        checkOutput("turn_grant", 32'(bus_if.grant), 32'd0);
        checkOutput("turn_valid", 32'(bus_if.bus_valid), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        settle();

        // Lone requester is regranted after TURN
        serve(2, 1, 4'b0000, 1'b1, 1);
        serve(2, 1, 4'b0000, 1'b0, -1);
        settle();

        // Simultaneous requests resolved from ptr=3: requester 3 before 0
        bus_if.req[0]       = 1'b1;
        bus_if.req_valid[0] = 1'b1;
        serve(3, 2, 4'b0000, 1'b0, 1);
        serve(0, 1, 4'b0000, 1'b0, -1);
        settle();

`ifdef ARB_TIMEOUT_EN
        // Stalled owner 2 is forced off after 255 cycles and masked until req toggles
        begin
            int c_evt;
            bus_if.bus_ready = 1'b0;
            exp_grant_q.push_back(4'b0100);
            bus_if.req[2]       = 1'b1;
            bus_if.req_valid[2] = 1'b1;
            wait_grant(4'b0100, lat);
            c_evt = -1;
            for (int c = 1; c < 400; c++) begin
                @(negedge clk);
                if (timeout_evt === 1'b1) begin
                    c_evt = c;
                    break;
                end
            end
            checkOutput("timeout_cycles", 32'(c_evt), 32'd255);
            checkOutput("timeout_grant", 32'(bus_if.grant), 32'd0);
            @(negedge clk);
            checkOutput("timeout_pulse_len", 32'(timeout_evt), 32'd0);
            repeat (10) @(negedge clk);
            checkOutput("masked_no_grant", 32'(bus_if.grant), 32'd0);
            @(posedge clk);
            #1;
            bus_if.req[2] = 1'b0;
            @(posedge clk);
            #1;
            exp_grant_q.push_back(4'b0100);
            bus_if.req[2] = 1'b1;
            wait_grant(4'b0100, lat);
            @(posedge clk);
            #1;
            applyStimulus(4'b0000, 4'b0000, 1'b0);
            settle();
        end
`endif

        repeat (3) @(negedge clk);
        checkOutput("beat_q_empty", 32'(exp_beat_q.size()), 32'd0);
        checkOutput("grant_q_empty", 32'(exp_grant_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
